// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode, command, state and flag-index definitions for the sequenced ALU
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    CMD_LOAD_A   = 2'b00,
    CMD_LOAD_B   = 2'b01,
    CMD_EXEC     = 2'b10,
    CMD_EXEC_ACC = 2'b11
  } cmd_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;

  // Flag vector is {Z, N, C, V} so it drops straight into uio_out[6:3]
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational single-cycle ALU ops and flag generation
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   shl_ext;
  logic [SW-1:0]        shamt;
  logic                 c;
  logic                 v;

  assign shamt   = b[SW-1:0];
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  // Bit WIDTH of the widened shift is the last bit pushed out of the result
  assign shl_ext = {{WIDTH{1'b0}}, a} << shamt;

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        c      = ~diff[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHL: begin
        result = shl_ext[WIDTH-1:0];
        c      = shl_ext[WIDTH];
      end
      default: result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, shl_ext[2*WIDTH-1:WIDTH+1]};

endmodule

// File: rtl/tt_um_alu_seq.sv
// rtl/tt_um_alu_seq.sv - strobed command ALU with register file, flags and shift-add multiplier
module tt_um_alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e               state;
  state_e               state_next;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     r;
  logic [3:0]           flags;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 mul_acc;
  logic                 busy;
  logic                 accept;
  logic                 is_exec;
  logic                 mul_start;
  logic                 mul_done;
  logic [3:0]           mul_flags;
  logic [WIDTH-1:0]     core_result;
  logic [3:0]           core_flags;
  cmd_e                 cmd;
  op_e                  op;

  assign cmd       = cmd_e'(uio_in[1:0]);
  assign op        = op_e'(ui_in[7:5]);
  assign accept    = uio_in[2] && !busy;
  assign is_exec   = (cmd == CMD_EXEC) || (cmd == CMD_EXEC_ACC);
  assign mul_start = accept && is_exec && (op == OP_MUL);
  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign mul_done  = (cnt == CW'(WIDTH - 1));

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (acc_next[WIDTH-1:0] == '0);
    mul_flags[FLAG_N] = acc_next[WIDTH-1];
    mul_flags[FLAG_C] = |acc_next[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_V] = |acc_next[2*WIDTH-1:WIDTH];
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .op     (ui_in[7:5]),
    .result (core_result),
    .flags  (core_flags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (mul_start) state_next = ST_MUL_RUN;
      ST_MUL_RUN: if (mul_done)  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_MUL_RUN);
  end

  // A and B are never written while busy, so the multiply sees them frozen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a       <= '0;
      b       <= '0;
      r       <= '0;
      flags   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      mul_acc <= 1'b0;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (mul_done) begin
        r     <= acc_next[WIDTH-1:0];
        flags <= mul_flags;
        cnt   <= '0;
        if (mul_acc) a <= acc_next[WIDTH-1:0];
      end
    end else if (accept) begin
      case (cmd)
        CMD_LOAD_A: a <= ui_in[WIDTH-1:0];
        CMD_LOAD_B: b <= ui_in[WIDTH-1:0];
        default: begin
          if (op == OP_MUL) begin
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            cnt     <= '0;
            mul_acc <= (cmd == CMD_EXEC_ACC);
          end else begin
            r     <= core_result;
            flags <= core_flags;
            if (cmd == CMD_EXEC_ACC) a <= core_result;
          end
        end
      endcase
    end
  end

  assign uo_out  = 8'(r);
  assign uio_out = {busy, flags, 3'b000};
  assign uio_oe  = 8'hF8;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_alu_seq.sv
// tb/tb_tt_um_alu_seq.sv - directed self-checking bench for tt_um_alu_seq at WIDTH 8 and 4
module tb_tt_um_alu_seq;

  localparam logic [1:0] LA  = 2'b00;
  localparam logic [1:0] LB  = 2'b01;
  localparam logic [1:0] EX  = 2'b10;
  localparam logic [1:0] EXA = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic [7:0] ui_in4, uio_in4, uo_out4, uio_out4, uio_oe4;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  tt_um_alu_seq dut8 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in4), .uio_in(uio_in4),
    .uo_out(uo_out4), .uio_out(uio_out4), .uio_oe(uio_oe4)
  );

  task automatic issue(input logic [1:0] c, input logic [7:0] d);
    @(negedge clk);
    ui_in  = d;
    uio_in = {5'b0, 1'b1, c};
    @(posedge clk);
    #1;
    uio_in = 8'h00;
  endtask

  task automatic issue4(input logic [1:0] c, input logic [7:0] d);
    @(negedge clk);
    ui_in4  = d;
    uio_in4 = {5'b0, 1'b1, c};
    @(posedge clk);
    #1;
    uio_in4 = 8'h00;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    ui_in   = 8'h55;
    uio_in  = {5'b0, 1'b1, LA};
    ui_in4  = 8'h55;
    uio_in4 = {5'b0, 1'b1, LA};
    repeat (3) @(posedge clk);
    #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_r got %h exp %h", uo_out, 8'h00); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_flags got %h exp %h", uio_out, 8'h00); end
    checks++; if (uio_oe !== 8'hF8) begin errors++; $display("FAIL reset_oe got %h exp %h", uio_oe, 8'hF8); end
    checks++; if (uo_out4 !== 8'h00) begin errors++; $display("FAIL reset_r4 got %h exp %h", uo_out4, 8'h00); end
    @(negedge clk);
    uio_in  = 8'h00;
    uio_in4 = 8'h00;
    rst_n   = 1'b1;
    issue(EX, 8'h00);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_strb_discard_r got %h exp %h", uo_out, 8'h00); end
    checks++; if (uio_out !== 8'h40) begin errors++; $display("FAIL reset_strb_discard_flags got %h exp %h", uio_out, 8'h40); end
  endtask

  task automatic test_add_overflow;
    issue(LA, 8'h7F);
    checks++; if (uio_out !== 8'h40) begin errors++; $display("FAIL load_keeps_flags got %h exp %h", uio_out, 8'h40); end
    issue(LB, 8'h01);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL load_keeps_r got %h exp %h", uo_out, 8'h00); end
    issue(EX, 8'h00);
    checks++; if (uo_out !== 8'h80) begin errors++; $display("FAIL add_r got %h exp %h", uo_out, 8'h80); end
    checks++; if (uio_out !== 8'h28) begin errors++; $display("FAIL add_flags got %h exp %h", uio_out, 8'h28); end
  endtask

  task automatic test_sub_slt;
    issue(LA, 8'h03);
    issue(LB, 8'h05);
    issue(EX, 8'h20);
    checks++; if (uo_out !== 8'hFE) begin errors++; $display("FAIL sub_r got %h exp %h", uo_out, 8'hFE); end
    checks++; if (uio_out !== 8'h20) begin errors++; $display("FAIL sub_flags got %h exp %h", uio_out, 8'h20); end
    issue(EX, 8'hA0);
    checks++; if (uo_out !== 8'h01) begin errors++; $display("FAIL slt_r got %h exp %h", uo_out, 8'h01); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL slt_flags got %h exp %h", uio_out, 8'h00); end
  endtask

  task automatic test_logic;
    issue(LA, 8'hF0);
    issue(LB, 8'h3C);
    issue(EX, 8'h40);
    checks++; if (uo_out !== 8'h30) begin errors++; $display("FAIL and_r got %h exp %h", uo_out, 8'h30); end
    issue(EX, 8'h60);
    checks++; if (uo_out !== 8'hFC) begin errors++; $display("FAIL or_r got %h exp %h", uo_out, 8'hFC); end
    checks++; if (uio_out !== 8'h20) begin errors++; $display("FAIL or_flags got %h exp %h", uio_out, 8'h20); end
    issue(EX, 8'h80);
    checks++; if (uo_out !== 8'hCC) begin errors++; $display("FAIL xor_r got %h exp %h", uo_out, 8'hCC); end
    issue(LB, 8'hF0);
    issue(EX, 8'h20);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL sub_eq_r got %h exp %h", uo_out, 8'h00); end
    checks++; if (uio_out !== 8'h50) begin errors++; $display("FAIL sub_eq_flags got %h exp %h", uio_out, 8'h50); end
  endtask

  task automatic test_shl;
    issue(LA, 8'h81);
    issue(LB, 8'h01);
    issue(EX, 8'hC0);
    checks++; if (uo_out !== 8'h02) begin errors++; $display("FAIL shl1_r got %h exp %h", uo_out, 8'h02); end
    checks++; if (uio_out !== 8'h10) begin errors++; $display("FAIL shl1_flags got %h exp %h", uio_out, 8'h10); end
    issue(LB, 8'h00);
    issue(EX, 8'hC0);
    checks++; if (uo_out !== 8'h81) begin errors++; $display("FAIL shl0_r got %h exp %h", uo_out, 8'h81); end
    checks++; if (uio_out !== 8'h20) begin errors++; $display("FAIL shl0_flags got %h exp %h", uio_out, 8'h20); end
    issue(LA, 8'h83);
    issue(LB, 8'h07);
    issue(EX, 8'hC0);
    checks++; if (uo_out !== 8'h80) begin errors++; $display("FAIL shl7_r got %h exp %h", uo_out, 8'h80); end
    checks++; if (uio_out !== 8'h30) begin errors++; $display("FAIL shl7_flags got %h exp %h", uio_out, 8'h30); end
    checks++; if (uio_oe !== 8'hF8) begin errors++; $display("FAIL shl_oe got %h exp %h", uio_oe, 8'hF8); end
  endtask

  task automatic test_mul;
    int n;
    issue(LA, 8'h10);
    issue(LB, 8'h11);
    issue(EX, 8'hE0);
    checks++; if (uio_out[7] !== 1'b1) begin errors++; $display("FAIL mul_busy_start got %b exp %b", uio_out[7], 1'b1); end
    @(negedge clk);
    ui_in  = 8'hAA;
    uio_in = {5'b0, 1'b1, LA};
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      uio_in = 8'h00;
      if (uio_out[7] === 1'b1) n++;
      else break;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL mul_busy_cycles got %0d exp %0d", n, 8); end
    checks++; if (uo_out !== 8'h10) begin errors++; $display("FAIL mul_r got %h exp %h", uo_out, 8'h10); end
    checks++; if (uio_out !== 8'h18) begin errors++; $display("FAIL mul_flags got %h exp %h", uio_out, 8'h18); end
    issue(EX, 8'h40);
    checks++; if (uo_out !== 8'h10) begin errors++; $display("FAIL mul_a_frozen got %h exp %h", uo_out, 8'h10); end
  endtask

  task automatic test_mul_acc;
    int n;
    issue(LA, 8'h03);
    issue(LB, 8'h05);
    issue(EXA, 8'hE0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (uio_out[7] === 1'b1) n++;
      else break;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL mulacc_busy_cycles got %0d exp %0d", n, 8); end
    checks++; if (uo_out !== 8'h0F) begin errors++; $display("FAIL mulacc_r got %h exp %h", uo_out, 8'h0F); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL mulacc_flags got %h exp %h", uio_out, 8'h00); end
    issue(EX, 8'h00);
    checks++; if (uo_out !== 8'h14) begin errors++; $display("FAIL mulacc_writeback got %h exp %h", uo_out, 8'h14); end
  endtask

  task automatic test_acc_chain4;
    logic [7:0] exp_r;
    issue4(LA, 8'hF3);
    issue4(LB, 8'h01);
    for (int i = 1; i <= 13; i++) begin
      issue4(EXA, 8'h00);
      exp_r = 8'((3 + i) % 16);
      checks++; if (uo_out4 !== exp_r) begin errors++; $display("FAIL acc4_step%0d got %h exp %h", i, uo_out4, exp_r); end
    end
    checks++; if (uio_out4 !== 8'h50) begin errors++; $display("FAIL acc4_wrap_flags got %h exp %h", uio_out4, 8'h50); end
  endtask

  task automatic test_reset_mul;
    issue(LA, 8'h0F);
    issue(LB, 8'h0F);
    issue(EX, 8'hE0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (uio_out[7] !== 1'b1) begin errors++; $display("FAIL rstmul_busy got %b exp %b", uio_out[7], 1'b1); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL rstmul_r got %h exp %h", uo_out, 8'h00); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL rstmul_flags got %h exp %h", uio_out, 8'h00); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL rstmul_no_partial got %h exp %h", uo_out, 8'h00); end
    issue(EX, 8'h00);
    checks++; if (uio_out !== 8'h40) begin errors++; $display("FAIL rstmul_ab_zero got %h exp %h", uio_out, 8'h40); end
    issue(LA, 8'h05);
    issue(LB, 8'h06);
    issue(EX, 8'h00);
    checks++; if (uo_out !== 8'h0B) begin errors++; $display("FAIL rstmul_fresh_add got %h exp %h", uo_out, 8'h0B); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL rstmul_fresh_flags got %h exp %h", uio_out, 8'h00); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_slt();
    test_logic();
    test_shl();
    test_mul();
    test_mul_acc();
    test_acc_chain4();
    test_reset_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
